// File: rtl/alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// alu_operand_sequencer
//
// Board front end for the 6-bit ALU. The user sets the slide switches and
// presses ENTER three times to load operand A, operand B and the function
// select. The ALU inputs are then held for one execute cycle, and the
// combinational ALU result is latched for display. CLEAR aborts the sequence
// at any point.
//
// Both pushbuttons pass through the same conditioning path:
//   two-flop synchroniser -> debounce counter -> rising-edge detector
// This produces one single-cycle pulse per accepted press (enter_p, clear_p).
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles before a button level is
//                    accepted (minimum 1)
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high
//   sw[5:0]       slide switches (quasi-static, not synchronised)
//   btn_enter     raw ENTER pushbutton (asynchronous, active-high)
//   btn_clear     raw CLEAR pushbutton (asynchronous, active-high)
//   alu_a[5:0]    registered operand A to the ALU
//   alu_b[5:0]    registered operand B to the ALU
//   alu_fxn[2:0]  registered function select to the ALU
//   alu_x[5:0]    combinational result from the ALU
//   result[5:0]   latched ALU result
//   result_valid  high while result holds a completed operation
//   state_led     one-hot FSM state (also the FSM debug view):
//                 bit0 GET_A, bit1 GET_B, bit2 GET_FXN, bit3 EXEC, bit4 SHOW
//
// Output qualification: there is no backpressure. result is meaningful only
// while result_valid is high. It rises on the clock edge that ends EXEC and
// falls when the user leaves SHOW or presses CLEAR.
// -----------------------------------------------------------------------------
module alu_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [5:0] alu_a,
    output logic [5:0] alu_b,
    output logic [2:0] alu_fxn,
    input  logic [5:0] alu_x,
    output logic [5:0] result,
    output logic       result_valid,
    output logic [4:0] state_led
);

    // Counter wide enough to hold DEBOUNCE_CYCLES-1.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // The state encoding is one-hot, so the state register drives the LEDs directly.
    typedef enum logic [4:0] {
        GET_A   = 5'b00001,
        GET_B   = 5'b00010,
        GET_FXN = 5'b00100,
        EXEC    = 5'b01000,
        SHOW    = 5'b10000
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning. Index 0 is ENTER and index 1 is CLEAR.
    // ------------------------------------------------------------------
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    level;
    logic [1:0]    level_d;
    logic [CW-1:0] count [2];
    logic [1:0]    pulses;
    logic          enter_p;
    logic          clear_p;

    assign raw = {btn_clear, btn_enter};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int i = 0; i < 2; i++) begin
                count[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    count[i] <= '0;
                end else if (count[i] == CNT_LAST) begin
                    // The count reaches DEBOUNCE_CYCLES on this edge. The new
                    // debounced level is visible during the next cycle, which
                    // is DEBOUNCE_CYCLES cycles after the synchronised change.
                    level[i] <= sync2[i];
                    count[i] <= '0;
                end else begin
                    count[i] <= count[i] + CW'(1);
                end
            end
        end
    end

    // The pulse is high in the same cycle the debounced level first reads high.
    // A release is a falling edge and never produces a pulse.
    assign pulses  = level & ~level_d;
    assign enter_p = pulses[0];
    assign clear_p = pulses[1];

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [5:0] a_q, a_d;
    logic [5:0] b_q, b_d;
    logic [2:0] fxn_q, fxn_d;
    logic [5:0] res_q, res_d;
    logic       valid_q, valid_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= GET_A;
            a_q     <= '0;
            b_q     <= '0;
            fxn_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fxn_q   <= fxn_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fxn_d   = fxn_q;
        res_d   = res_q;
        valid_d = valid_q;

        if (clear_p) begin
            // CLEAR has priority. An ENTER pulse in the same cycle is dropped.
            state_d = GET_A;
            a_d     = '0;
            b_d     = '0;
            fxn_d   = '0;
            res_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                GET_A: begin
                    if (enter_p) begin
                        a_d     = sw;
                        state_d = GET_B;
                    end
                end
                GET_B: begin
                    if (enter_p) begin
                        b_d     = sw;
                        state_d = GET_FXN;
                    end
                end
                GET_FXN: begin
                    if (enter_p) begin
                        fxn_d   = sw[2:0];
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    // The operands were loaded one edge earlier, so the ALU
                    // has a full period to settle. ENTER is ignored here.
                    res_d   = alu_x;
                    valid_d = 1'b1;
                    state_d = SHOW;
                end
                SHOW: begin
                    // The switches are not looked at here. The result and
                    // the operands stay on display.
                    if (enter_p) begin
                        valid_d = 1'b0;
                        state_d = GET_A;
                    end
                end
                default: begin
                    state_d = GET_A;
                end
            endcase
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_fxn      = fxn_q;
    assign result       = res_q;
    assign result_valid = valid_q;
    assign state_led    = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_sequencer
//
// Directed bench for alu_operand_sequencer with DEBOUNCE_CYCLES = 4.
//
// A small ALU stand-in drives alu_x from the DUT's registered operands. It
// implements add (110), subtract (111) and XNOR (101). Expected results are
// spec constants pushed to exp_q when the function press is driven. They are
// popped when the DUT reaches SHOW.
//
// Button timing: a button raised just after edge t is seen as a state change
// after the 7th following edge. That is 2 synchroniser cycles, plus 4
// debounce cycles, plus the edge that ends the pulse cycle.
// -----------------------------------------------------------------------------
module tb_alu_operand_sequencer;

    localparam int DB = 4;

    localparam logic [4:0] L_GET_A   = 5'b00001;
    localparam logic [4:0] L_GET_B   = 5'b00010;
    localparam logic [4:0] L_GET_FXN = 5'b00100;
    localparam logic [4:0] L_EXEC    = 5'b01000;
    localparam logic [4:0] L_SHOW    = 5'b10000;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] sw;
    logic       btn_enter;
    logic       btn_clear;
    logic [5:0] alu_a;
    logic [5:0] alu_b;
    logic [2:0] alu_fxn;
    logic [5:0] alu_x;
    logic [5:0] result;
    logic       result_valid;
    logic [4:0] state_led;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [5:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    alu_operand_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk          (clk),
        .reset        (reset),
        .sw           (sw),
        .btn_enter    (btn_enter),
        .btn_clear    (btn_clear),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_fxn      (alu_fxn),
        .alu_x        (alu_x),
        .result       (result),
        .result_valid (result_valid),
        .state_led    (state_led)
    );

    // ---------------- ALU stand-in ----------------
    always_comb begin
        alu_x = '0;
        case (alu_fxn)
            3'b110:  alu_x = alu_a + alu_b;
            3'b111:  alu_x = alu_a - alu_b;
            3'b101:  alu_x = ~(alu_a ^ alu_b);
            default: alu_x = alu_a & alu_b;
        endcase
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Press ENTER long enough for one pulse. cur is the state before the
    // pulse, nxt the state one edge after it and fin the state one edge later.
    task automatic press_enter(input string tag, input logic [4:0] cur,
                               input logic [4:0] nxt, input logic [4:0] fin);
        logic [5:0] exp_res;
        btn_enter = 1'b1;
        repeat (6) tick();
        check({tag, "_hold6"}, 32'(state_led), 32'(cur));
        tick();
        check({tag, "_step"}, 32'(state_led), 32'(nxt));
        check({tag, "_rv_step"}, 32'(result_valid), 32'd0);
        tick();
        check({tag, "_after"}, 32'(state_led), 32'(fin));
        if (fin == L_SHOW) begin
            tests_run++;
            assert (exp_q.size() > 0) else begin
                tests_failed++;
                $error("FAIL %s_queue: observed empty expected entry", tag);
            end
            if (exp_q.size() > 0) begin
                exp_res = exp_q.pop_front();
                check({tag, "_result"}, 32'(result), 32'(exp_res));
                check({tag, "_rv"}, 32'(result_valid), 32'd1);
            end
        end
        btn_enter = 1'b0;
        repeat (12) tick();
        check({tag, "_once"}, 32'(state_led), 32'(fin));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset     = 1'b1;
        sw        = '0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_state", 32'(state_led), 32'(L_GET_A));
        check("rst_a", 32'(alu_a), 32'd0);
        check("rst_b", 32'(alu_b), 32'd0);
        check("rst_fxn", 32'(alu_fxn), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_rv", 32'(result_valid), 32'd0);

        // Glitch of 3 cycles, shorter than DB: no pulse.
        sw = 6'd5;
        btn_enter = 1'b1;
        repeat (3) tick();
        btn_enter = 1'b0;
        repeat (12) tick();
        check("glitch_state", 32'(state_led), 32'(L_GET_A));
        check("glitch_a", 32'(alu_a), 32'd0);

        // Add: 5 + 3 = 8
        press_enter("add_a", L_GET_A, L_GET_B, L_GET_B);
        check("add_a_val", 32'(alu_a), 32'd5);
        sw = 6'd3;
        press_enter("add_b", L_GET_B, L_GET_FXN, L_GET_FXN);
        check("add_b_val", 32'(alu_b), 32'd3);
        sw = 6'b000110;
        exp_q.push_back(6'd8);
        press_enter("add_f", L_GET_FXN, L_EXEC, L_SHOW);
        check("add_fxn_val", 32'(alu_fxn), 32'b110);
        press_enter("add_exit", L_SHOW, L_GET_A, L_GET_A);
        check("add_exit_result", 32'(result), 32'd8);

        // Subtract with wrap: 3 - 5 = 6'b111110
        sw = 6'd3;
        press_enter("sub_a", L_GET_A, L_GET_B, L_GET_B);
        sw = 6'd5;
        press_enter("sub_b", L_GET_B, L_GET_FXN, L_GET_FXN);
        sw = 6'b000111;
        exp_q.push_back(6'b111110);
        press_enter("sub_f", L_GET_FXN, L_EXEC, L_SHOW);
        for (int i = 0; i < 5; i++) begin
            sw = 6'($urandom_range(0, 63));
            tick();
            check("show_sw_result", 32'(result), 32'b111110);
            check("show_sw_a", 32'(alu_a), 32'd3);
            check("show_sw_rv", 32'(result_valid), 32'd1);
        end
        press_enter("sub_exit", L_SHOW, L_GET_A, L_GET_A);

        // XNOR: 101010 xnor 100110 = 110011
        sw = 6'b101010;
        press_enter("xnor_a", L_GET_A, L_GET_B, L_GET_B);
        sw = 6'b100110;
        press_enter("xnor_b", L_GET_B, L_GET_FXN, L_GET_FXN);
        sw = 6'b000101;
        exp_q.push_back(6'b110011);
        press_enter("xnor_f", L_GET_FXN, L_EXEC, L_SHOW);
        press_enter("xnor_exit", L_SHOW, L_GET_A, L_GET_A);
        check("xnor_exit_result", 32'(result), 32'b110011);
        check("xnor_exit_rv", 32'(result_valid), 32'd0);

        // Clear priority: ENTER and CLEAR pulse in the same cycle in GET_FXN.
        sw = 6'd9;
        press_enter("clr_a", L_GET_A, L_GET_B, L_GET_B);
        sw = 6'd4;
        press_enter("clr_b", L_GET_B, L_GET_FXN, L_GET_FXN);
        sw = 6'b000110;
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        repeat (6) tick();
        check("clr_hold6", 32'(state_led), 32'(L_GET_FXN));
        tick();
        check("clr_state", 32'(state_led), 32'(L_GET_A));
        check("clr_a_zero", 32'(alu_a), 32'd0);
        check("clr_b_zero", 32'(alu_b), 32'd0);
        check("clr_fxn_zero", 32'(alu_fxn), 32'd0);
        check("clr_result_zero", 32'(result), 32'd0);
        check("clr_rv_zero", 32'(result_valid), 32'd0);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (12) tick();
        check("clr_settle", 32'(state_led), 32'(L_GET_A));

        // Reset during EXEC, with ENTER still held through reset.
        sw = 6'd7;
        press_enter("rex_a", L_GET_A, L_GET_B, L_GET_B);
        sw = 6'd9;
        press_enter("rex_b", L_GET_B, L_GET_FXN, L_GET_FXN);
        sw = 6'b000110;
        btn_enter = 1'b1;
        repeat (7) tick();
        check("rex_in_exec", 32'(state_led), 32'(L_EXEC));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rex_state", 32'(state_led), 32'(L_GET_A));
        check("rex_rv", 32'(result_valid), 32'd0);
        check("rex_result", 32'(result), 32'd0);
        check("rex_a", 32'(alu_a), 32'd0);
        repeat (6) tick();
        check("rex_held_hold6", 32'(state_led), 32'(L_GET_A));
        tick();
        check("rex_held_pulse", 32'(state_led), 32'(L_GET_B));
        check("rex_held_a", 32'(alu_a), 32'd6);
        btn_enter = 1'b0;
        repeat (12) tick();
        check("rex_settle", 32'(state_led), 32'(L_GET_B));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
